// File: rtl/mailbox_irq_coalesce.sv
// Per-CPU interrupt coalescer: counts mailbox irq rising edges and raises a
// maskable interrupt on a count threshold or an age timeout; APB-programmed.
module mailbox_irq_coalesce #(
   parameter int N_NUMB_CPU  = 4,
   parameter int W_WIDTH_SYS = 32,
   parameter int CNT_W       = 8
) (
   input  logic                   pclk_i,
   input  logic                   preset_i,
   input  logic [N_NUMB_CPU-1:0]  irq_i,
   input  logic                   psel_i,
   input  logic                   penable_i,
   input  logic                   pwrite_i,
   input  logic [7:0]             paddr_i,
   input  logic [W_WIDTH_SYS-1:0] pwdata_i,
   output logic [W_WIDTH_SYS-1:0] prdata_o,
   output logic                   pready_o,
   output logic                   pslverr_o,
   output logic [N_NUMB_CPU-1:0]  irq_o
);

   localparam logic [7:0] A_ENABLE  = 8'h00;
   localparam logic [7:0] A_THRESH  = 8'h04;
   localparam logic [7:0] A_TIMEOUT = 8'h08;
   localparam logic [7:0] A_STATUS  = 8'h0C;
   localparam logic [7:0] A_ACK     = 8'h10;
   localparam logic [7:0] A_COUNT0  = 8'h20;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [15:0]      TMR_MAX = 16'hFFFF;

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

   function automatic logic [15:0] sat_inc_tmr(input logic [15:0] v);
      return (v == TMR_MAX) ? v : v + 1'b1;
   endfunction

   // A zero threshold would fire with no events pending, so it is promoted to 1.
   function automatic logic [CNT_W-1:0] thresh_fix(input logic [CNT_W-1:0] v);
      return (v == '0) ? CNT_W'(1) : v;
   endfunction

   logic [N_NUMB_CPU-1:0] enable_q;
   logic [CNT_W-1:0]      thresh_q;
   logic [15:0]           timeout_q;
   logic [N_NUMB_CPU-1:0] irq_q;
   logic [CNT_W-1:0]      cnt_q [N_NUMB_CPU];
   logic [15:0]           tmr_q [N_NUMB_CPU];
   logic [CNT_W-1:0]      cnt_d [N_NUMB_CPU];
   logic [15:0]           tmr_d [N_NUMB_CPU];
   logic [N_NUMB_CPU-1:0] rise;
   logic [N_NUMB_CPU-1:0] ack;
   logic [N_NUMB_CPU-1:0] fire;

   logic        access;
   logic        hit_enable, hit_thresh, hit_timeout, hit_status, hit_ack, hit_count;
   logic        rd_err, wr_err, wr_ok;
   logic [7:0]  cnt_off;
   logic [3:0]  cnt_idx;
   logic [31:0] rd_word;
   logic        unused_pwdata;

   assign unused_pwdata = ^pwdata_i;
   assign access        = psel_i & penable_i;
   assign pready_o      = access;

   always_comb begin
      cnt_off     = paddr_i - A_COUNT0;
      cnt_idx     = cnt_off[5:2];
      hit_enable  = (paddr_i == A_ENABLE);
      hit_thresh  = (paddr_i == A_THRESH);
      hit_timeout = (paddr_i == A_TIMEOUT);
      hit_status  = (paddr_i == A_STATUS);
      hit_ack     = (paddr_i == A_ACK);
      hit_count   = (paddr_i >= A_COUNT0) && (cnt_off[7:6] == 2'b00) &&
                    (cnt_off[1:0] == 2'b00) && (int'(cnt_idx) < N_NUMB_CPU);
      rd_err      = hit_ack | ~(hit_enable | hit_thresh | hit_timeout | hit_status | hit_count);
      wr_err      = ~(hit_enable | hit_thresh | hit_timeout | hit_ack);
      pslverr_o   = access & (pwrite_i ? wr_err : rd_err);
      wr_ok       = access & pwrite_i & ~wr_err;
   end

   always_comb begin
      rd_word = '0;
      if (hit_enable)  rd_word[N_NUMB_CPU-1:0] = enable_q;
      if (hit_thresh)  rd_word[CNT_W-1:0]      = thresh_q;
      if (hit_timeout) rd_word[15:0]           = timeout_q;
      if (hit_status)  rd_word[N_NUMB_CPU-1:0] = irq_o;
      if (hit_count) begin
         for (int i = 0; i < N_NUMB_CPU; i++) begin
            if (cnt_idx == 4'(i)) begin
               rd_word[31:16]      = tmr_q[i];
               rd_word[CNT_W-1:0]  = cnt_q[i];
            end
         end
      end
      prdata_o = '0;
      if (access && !pwrite_i && !rd_err) prdata_o[31:0] = rd_word;
   end

   // An ACK on the same edge as a new rise keeps that rise as the first event.
   always_comb begin
      rise = irq_i & ~irq_q;
      ack  = (wr_ok && hit_ack) ? pwdata_i[N_NUMB_CPU-1:0] : '0;
      fire = '0;
      for (int i = 0; i < N_NUMB_CPU; i++) begin
         fire[i] = (cnt_q[i] >= thresh_q) ||
                   ((timeout_q != '0) && (tmr_q[i] >= timeout_q));
         if (ack[i]) begin
            cnt_d[i] = rise[i] ? CNT_W'(1) : '0;
            tmr_d[i] = '0;
         end else begin
            cnt_d[i] = rise[i] ? sat_inc_cnt(cnt_q[i]) : cnt_q[i];
            tmr_d[i] = (cnt_q[i] != '0) ? sat_inc_tmr(tmr_q[i]) : '0;
         end
      end
   end

   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         enable_q  <= '0;
         thresh_q  <= CNT_W'(1);
         timeout_q <= '0;
      end else if (wr_ok) begin
         if (hit_enable)  enable_q  <= pwdata_i[N_NUMB_CPU-1:0];
         if (hit_thresh)  thresh_q  <= thresh_fix(pwdata_i[CNT_W-1:0]);
         if (hit_timeout) timeout_q <= pwdata_i[15:0];
      end
   end

   // Event state and coalesced output; irq_o follows fire one cycle later.
   always_ff @(posedge pclk_i or posedge preset_i) begin
      if (preset_i) begin
         irq_q <= '0;
         irq_o <= '0;
         for (int i = 0; i < N_NUMB_CPU; i++) begin
            cnt_q[i] <= '0;
            tmr_q[i] <= '0;
         end
      end else begin
         irq_q <= irq_i;
         irq_o <= enable_q & fire;
         for (int i = 0; i < N_NUMB_CPU; i++) begin
            cnt_q[i] <= cnt_d[i];
            tmr_q[i] <= tmr_d[i];
         end
      end
   end

endmodule

// File: tb/tb_mailbox_irq_coalesce.sv
// Bench for mailbox_irq_coalesce: register table, APB read scoreboard and
// hand-written timing sequences for coalescing, masking, ACK and reset.
module tb_mailbox_irq_coalesce;

   localparam int N  = 4;
   localparam int W  = 32;
   localparam int CW = 8;

   logic          pclk = 1'b0;
   logic          preset;
   logic [N-1:0]  irq_i;
   logic          psel, penable, pwrite;
   logic [7:0]    paddr;
   logic [W-1:0]  pwdata;
   logic [W-1:0]  prdata;
   logic          pready, pslverr;
   logic [N-1:0]  irq_o;

   always #5 pclk = ~pclk;

   mailbox_irq_coalesce #(.N_NUMB_CPU(N), .W_WIDTH_SYS(W), .CNT_W(CW)) dut (
      .pclk_i(pclk), .preset_i(preset), .irq_i(irq_i),
      .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
      .pready_o(pready), .pslverr_o(pslverr), .irq_o(irq_o)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic [31:0] exp;
      logic [31:0] mask;
      logic        err;
   } sb_t;
   sb_t sb_q[$];

   typedef struct {
      logic        wr;
      logic [7:0]  addr;
      logic [31:0] data;
      logic [31:0] exp;
      logic        err;
   } vec_t;
   vec_t vt[25];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [31:0] exp,
                          input logic [31:0] mask, input logic err);
      sb_t e;
      e.name = name; e.exp = exp; e.mask = mask; e.err = err;
      sb_q.push_back(e);
   endtask

   task automatic sb_sample();
      sb_t e;
      if (sb_q.size() == 0) begin
         n_err++;
         $display("FAIL sb_underflow: got empty queue, want an entry");
         return;
      end
      e = sb_q.pop_front();
      check({e.name, "_rdata"}, prdata & e.mask, e.exp & e.mask);
      check({e.name, "_err"}, {31'b0, pslverr}, {31'b0, e.err});
      check({e.name, "_rdy"}, {31'b0, pready}, 32'd1);
   endtask

   // Called #1 after an edge; returns #1 after the access-phase edge.
   task automatic apb_read(input string name, input logic [7:0] addr, input logic [31:0] exp,
                           input logic [31:0] mask, input logic err);
      sb_push(name, exp, mask, err);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
      @(posedge pclk); #1 penable = 1'b1;
      #1 sb_sample();
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
   endtask

   task automatic apb_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                            input logic err);
      sb_push(name, 32'h0, 32'hFFFF_FFFF, err);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
      @(posedge pclk); #1 penable = 1'b1;
      #1 sb_sample();
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
   endtask

   task automatic pulse(input int k);
      irq_i[k] = 1'b1;
      @(posedge pclk); #1 irq_i[k] = 1'b0;
      @(posedge pclk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation still running, want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      preset = 1'b1; irq_i = '0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0;

      vt[0]  = '{1'b0, 8'h00, 32'h0,       32'h0,    1'b0};
      vt[1]  = '{1'b0, 8'h04, 32'h0,       32'h1,    1'b0};
      vt[2]  = '{1'b0, 8'h08, 32'h0,       32'h0,    1'b0};
      vt[3]  = '{1'b0, 8'h0C, 32'h0,       32'h0,    1'b0};
      vt[4]  = '{1'b0, 8'h20, 32'h0,       32'h0,    1'b0};
      vt[5]  = '{1'b0, 8'h2C, 32'h0,       32'h0,    1'b0};
      vt[6]  = '{1'b0, 8'h10, 32'h0,       32'h0,    1'b1};
      vt[7]  = '{1'b0, 8'h18, 32'h0,       32'h0,    1'b1};
      vt[8]  = '{1'b0, 8'h30, 32'h0,       32'h0,    1'b1};
      vt[9]  = '{1'b0, 8'h22, 32'h0,       32'h0,    1'b1};
      vt[10] = '{1'b1, 8'h04, 32'h100,     32'h0,    1'b0};
      vt[11] = '{1'b0, 8'h04, 32'h0,       32'h1,    1'b0};
      vt[12] = '{1'b1, 8'h04, 32'h5,       32'h0,    1'b0};
      vt[13] = '{1'b0, 8'h04, 32'h0,       32'h5,    1'b0};
      vt[14] = '{1'b1, 8'h08, 32'h12345,   32'h0,    1'b0};
      vt[15] = '{1'b0, 8'h08, 32'h0,       32'h2345, 1'b0};
      vt[16] = '{1'b1, 8'h00, 32'hFF,      32'h0,    1'b0};
      vt[17] = '{1'b0, 8'h00, 32'h0,       32'hF,    1'b0};
      vt[18] = '{1'b1, 8'h0C, 32'h1,       32'h0,    1'b1};
      vt[19] = '{1'b1, 8'h24, 32'h1,       32'h0,    1'b1};
      vt[20] = '{1'b1, 8'h18, 32'hFFFF,    32'h0,    1'b1};
      vt[21] = '{1'b1, 8'h00, 32'h0,       32'h0,    1'b0};
      vt[22] = '{1'b1, 8'h08, 32'h0,       32'h0,    1'b0};
      vt[23] = '{1'b1, 8'h04, 32'h1,       32'h0,    1'b0};
      vt[24] = '{1'b0, 8'h0C, 32'h0,       32'h0,    1'b0};

      repeat (3) @(posedge pclk);
      #1;
      check("rst_irq_o",   {28'b0, irq_o}, 32'h0);
      check("rst_prdata",  prdata, 32'h0);
      check("rst_pslverr", {31'b0, pslverr}, 32'h0);
      check("rst_pready",  {31'b0, pready}, 32'h0);
      preset = 1'b0;
      @(posedge pclk); #1;

      for (int i = 0; i < 25; i++) begin
         if (vt[i].wr)
            apb_write($sformatf("vec%0d", i), vt[i].addr, vt[i].data, vt[i].err);
         else
            apb_read($sformatf("vec%0d", i), vt[i].addr, vt[i].exp, 32'hFFFF_FFFF, vt[i].err);
      end

      // Threshold coalescing on CPU1
      apb_write("t1_thresh", 8'h04, 32'd3, 1'b0);
      apb_write("t1_enable", 8'h00, 32'hF, 1'b0);
      pulse(1);
      pulse(1);
      irq_i[1] = 1'b1;
      @(posedge pclk); #1 irq_i[1] = 1'b0;
      check("t1_irq_before", {28'b0, irq_o}, 32'h0);
      @(posedge pclk); #1;
      check("t1_irq_after", {28'b0, irq_o}, 32'h2);
      apb_read("t1_count1", 8'h24, 32'd3, 32'h0000_00FF, 1'b0);
      apb_read("t1_status", 8'h0C, 32'h2, 32'hFFFF_FFFF, 1'b0);

      // Timeout firing on CPU0
      apb_write("t2_ack1", 8'h10, 32'h2, 1'b0);
      apb_write("t2_thresh", 8'h04, 32'd8, 1'b0);
      apb_write("t2_timeout", 8'h08, 32'd10, 1'b0);
      check("t2_irq_idle", {28'b0, irq_o}, 32'h0);
      irq_i[0] = 1'b1;
      @(posedge pclk); #1 irq_i[0] = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge pclk); #1;
         check($sformatf("t2_irq_wait%0d", k), {28'b0, irq_o}, 32'h0);
      end
      sb_push("t2_count0_fire", 32'h000A_0001, 32'hFFFF_FFFF, 1'b0);
      psel = 1'b1; pwrite = 1'b0; paddr = 8'h20;
      @(posedge pclk); #1 penable = 1'b1;
      check("t2_irq_t10", {28'b0, irq_o}, 32'h0);
      #1 sb_sample();
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
      check("t2_irq_t11", {28'b0, irq_o}, 32'h1);

      // ACK and new rise on the same edge
      psel = 1'b1; pwrite = 1'b1; paddr = 8'h10; pwdata = 32'h1;
      @(posedge pclk); #1 penable = 1'b1; irq_i[0] = 1'b1;
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; irq_i[0] = 1'b0;
      check("t3_irq_ack_edge", {28'b0, irq_o}, 32'h1);
      sb_push("t3_count0", 32'h0001_0001, 32'hFFFF_FFFF, 1'b0);
      psel = 1'b1; paddr = 8'h20;
      @(posedge pclk); #1 penable = 1'b1;
      check("t3_irq_dropped", {28'b0, irq_o}, 32'h0);
      #1 sb_sample();
      @(posedge pclk); #1 psel = 1'b0; penable = 1'b0;
      apb_write("t3_timeout0", 8'h08, 32'd0, 1'b0);
      apb_write("t3_ackall", 8'h10, 32'hF, 1'b0);

      // Masked counting and enable/disable latency
      apb_write("t4_thresh", 8'h04, 32'd2, 1'b0);
      apb_write("t4_disable", 8'h00, 32'h0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         pulse(2);
         check($sformatf("t4_masked%0d", k), {28'b0, irq_o}, 32'h0);
      end
      apb_read("t4_count2", 8'h28, 32'd5, 32'h0000_00FF, 1'b0);
      apb_write("t4_enable", 8'h00, 32'h4, 1'b0);
      check("t4_en_edge", {28'b0, irq_o}, 32'h0);
      @(posedge pclk); #1;
      check("t4_en_next", {28'b0, irq_o}, 32'h4);
      apb_write("t4_mask", 8'h00, 32'h0, 1'b0);
      check("t4_dis_edge", {28'b0, irq_o}, 32'h4);
      @(posedge pclk); #1;
      check("t4_dis_next", {28'b0, irq_o}, 32'h0);

      // Saturation, held level, threshold zero
      apb_write("t5_ackall", 8'h10, 32'hF, 1'b0);
      for (int k = 0; k < 300; k++) pulse(3);
      apb_read("t5_sat", 8'h2C, 32'd255, 32'h0000_00FF, 1'b0);
      apb_write("t5_ack3", 8'h10, 32'h8, 1'b0);
      irq_i[3] = 1'b1;
      repeat (50) @(posedge pclk);
      #1;
      apb_read("t5_held", 8'h2C, 32'd1, 32'h0000_00FF, 1'b0);
      irq_i[3] = 1'b0;
      apb_write("t5_ack3b", 8'h10, 32'h8, 1'b0);
      apb_write("t5_thresh0", 8'h04, 32'd0, 1'b0);
      apb_read("t5_thresh_rb", 8'h04, 32'd1, 32'hFFFF_FFFF, 1'b0);

      // Erroring accesses leave state alone; async reset mid-operation
      apb_write("t6_enable", 8'h00, 32'hF, 1'b0);
      pulse(1);
      apb_read("t6_rd_hole", 8'h18, 32'h0, 32'hFFFF_FFFF, 1'b1);
      apb_read("t6_rd_ack", 8'h10, 32'h0, 32'hFFFF_FFFF, 1'b1);
      apb_write("t6_wr_status", 8'h0C, 32'hF, 1'b1);
      apb_write("t6_wr_count", 8'h24, 32'hFFFF_FFFF, 1'b1);
      apb_read("t6_enable_rb", 8'h00, 32'hF, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_thresh_rb", 8'h04, 32'h1, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_count1", 8'h24, 32'd1, 32'h0000_00FF, 1'b0);
      apb_read("t6_status", 8'h0C, 32'h2, 32'hFFFF_FFFF, 1'b0);
      irq_i[3] = 1'b1;
      @(posedge pclk); #1 irq_i[3] = 1'b0;
      @(posedge pclk); #1;
      check("t6_pre_reset", {28'b0, irq_o}, 32'hA);
      #2 preset = 1'b1;
      #1;
      check("t6_rst_irq_o", {28'b0, irq_o}, 32'h0);
      check("t6_rst_prdata", prdata, 32'h0);
      check("t6_rst_pslverr", {31'b0, pslverr}, 32'h0);
      repeat (2) @(posedge pclk);
      #1 preset = 1'b0;
      @(posedge pclk); #1;
      check("t6_post_irq_o", {28'b0, irq_o}, 32'h0);
      apb_read("t6_post_enable", 8'h00, 32'h0, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_post_thresh", 8'h04, 32'h1, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_post_timeout", 8'h08, 32'h0, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_post_status", 8'h0C, 32'h0, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_post_count1", 8'h24, 32'h0, 32'hFFFF_FFFF, 1'b0);
      apb_read("t6_post_count3", 8'h2C, 32'h0, 32'hFFFF_FFFF, 1'b0);

      if (sb_q.size() != 0) begin
         n_err++;
         $display("FAIL sb_leftover: got %0d entries, want 0", sb_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
